// File: rtl/scramble_pkg.sv
// Shared definitions for the scramble handshake initiator: FSM encoding, code geometry,
// LFSR taps and the raw-to-face code reduction.
package scramble_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_GEN  = 2'b01,
        ST_SEND = 2'b10,
        ST_WAIT = 2'b11
    } state_t;

    localparam int CODE_W = 3;
    localparam int SLOT_N = 6;
    localparam int FACE_N = 6;

    // x^16 + x^14 + x^13 + x^11 + 1 -> register bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef logic [CODE_W-1:0] code_t;

    function automatic code_t reduce_code(input logic [CODE_W-1:0] raw);
        return (raw >= CODE_W'(FACE_N)) ? raw - CODE_W'(FACE_N) : raw;
    endfunction

endpackage

// File: rtl/scramble_lfsr.sv
// 16-bit Fibonacci LFSR (shift left, feedback into bit 0) with seed load and enable.
// The code output is taken from the value the register moves to on the next enabled edge.
module scramble_lfsr
    import scramble_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [CODE_W-1:0] code
);

    // An all-zero seed would lock the register up forever.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] state;
    logic [15:0] state_next;

    assign state_next = {state[14:0], ^(state & LFSR_TAPS)};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= SEED_EFF;
        end else if (en) begin
            state <= state_next;
        end
    end

    assign code = reduce_code(state_next[CODE_W-1:0]);

endmodule

// File: rtl/scramble_source.sv
// Initiator of the six-code scramble handshake: generates batches, pulses ready, waits for done.
// Optional echo comparison and mismatch counting are built only when ECHO_CHECK_EN is defined.
module scramble_source
    import scramble_pkg::*;
#(
    parameter int unsigned ROUNDS  = 4,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              done,
    input  logic [CODE_W-1:0] i1,
    input  logic [CODE_W-1:0] i2,
    input  logic [CODE_W-1:0] i3,
    input  logic [CODE_W-1:0] i4,
    input  logic [CODE_W-1:0] i5,
    input  logic [CODE_W-1:0] i6,
    output logic              ready,
    output logic [CODE_W-1:0] o1,
    output logic [CODE_W-1:0] o2,
    output logic [CODE_W-1:0] o3,
    output logic [CODE_W-1:0] o4,
    output logic [CODE_W-1:0] o5,
    output logic [CODE_W-1:0] o6,
    output logic              busy,
    output logic [7:0]        round_cnt,
    output logic              timeout_err,
    output logic [7:0]        mismatch_cnt
);

    localparam logic [7:0] ROUNDS_L  = 8'(ROUNDS);
    localparam logic [7:0] TIMEOUT_L = 8'(TIMEOUT);

    state_t            state;
    logic [2:0]        slot;
    logic [7:0]        tmo;
    code_t             codes [SLOT_N];
    logic [CODE_W-1:0] lfsr_code;

    scramble_lfsr #(.SEED(SEED)) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .en   (state == ST_GEN),
        .code (lfsr_code)
    );

    // NOTE: state and every registered output use non-blocking assignments so all
    // flops update together at the edge, whatever order the statements are written in.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            slot        <= '0;
            tmo         <= '0;
            ready       <= 1'b0;
            busy        <= 1'b0;
            round_cnt   <= '0;
            timeout_err <= 1'b0;
            // NOTE: the code slots are a handful of visible output flops, not a RAM,
            // so they are reset along with the control state.
            codes       <= '{default: '0};
        end else begin
            ready <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_GEN;
                        busy        <= 1'b1;
                        slot        <= '0;
                        round_cnt   <= '0;
                        timeout_err <= 1'b0;
                    end
                end
                ST_GEN: begin
                    codes[slot] <= lfsr_code;
                    if (slot == 3'(SLOT_N - 1)) begin
                        slot  <= '0;
                        ready <= 1'b1;
                        state <= ST_SEND;
                    end else begin
                        slot <= slot + 3'd1;
                    end
                end
                ST_SEND: begin
                    tmo   <= TIMEOUT_L;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // done wins over an expiry landing in the same cycle
                    if (done) begin
                        round_cnt <= round_cnt + 8'd1;
                        if (round_cnt + 8'd1 == ROUNDS_L) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= ST_GEN;
                        end
                    end else if (tmo == 8'd1) begin
                        timeout_err <= 1'b1;
                        state       <= ST_IDLE;
                        busy        <= 1'b0;
                    end else begin
                        tmo <= tmo - 8'd1;
                    end
                end
            endcase
        end
    end

    assign o1 = codes[0];
    assign o2 = codes[1];
    assign o3 = codes[2];
    assign o4 = codes[3];
    assign o5 = codes[4];
    assign o6 = codes[5];

`ifdef ECHO_CHECK_EN
    logic echo_diff;
    assign echo_diff = {i1, i2, i3, i4, i5, i6} != {o1, o2, o3, o4, o5, o6};

    // One count per accepted round with any differing slot, saturating at 255.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mismatch_cnt <= '0;
        end else if (state == ST_IDLE && start) begin
            mismatch_cnt <= '0;
        end else if (state == ST_WAIT && done && echo_diff && mismatch_cnt != 8'hFF) begin
            mismatch_cnt <= mismatch_cnt + 8'd1;
        end
    end
`else
    logic unused_echo;
    assign unused_echo  = ^{i1, i2, i3, i4, i5, i6};
    assign mismatch_cnt = '0;
`endif

endmodule

// File: tb/tb_scramble_source.sv
// Scoreboard bench for scramble_source: a polynomial-level LFSR model predicts every batch,
// a checker model answers ready with randomised latency, and a monitor compares each batch.
module tb_scramble_source;

    localparam int          ROUNDS  = 4;
    localparam int          TIMEOUT = 15;
    localparam logic [15:0] SEED    = 16'hACE1;
`ifdef ECHO_CHECK_EN
    localparam int EXP_MIS = 1;
`else
    localparam int EXP_MIS = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       done = 1'b0;
    logic [2:0] i1, i2, i3, i4, i5, i6;
    logic [2:0] o1, o2, o3, o4, o5, o6;
    logic       ready, busy, timeout_err;
    logic [7:0] round_cnt, mismatch_cnt;

    scramble_source #(.ROUNDS(ROUNDS), .SEED(SEED), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done),
        .i1(i1), .i2(i2), .i3(i3), .i4(i4), .i5(i5), .i6(i6),
        .ready(ready),
        .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6),
        .busy(busy), .round_cnt(round_cnt), .timeout_err(timeout_err),
        .mismatch_cnt(mismatch_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the polynomial applied literally to a 16-bit word.
    logic [15:0] m_lfsr;
    logic [17:0] exp_q[$];
    int          ready_cyc[$];

    function automatic logic [2:0] face_of(input logic [15:0] s);
        int v;
        v = int'(s) % 8;
        if (v >= 6) v = v - 6;
        return 3'(v);
    endfunction

    task automatic model_step();
        int   taps[4];
        logic fb;
        taps = '{16, 14, 13, 11};
        fb = 1'b0;
        foreach (taps[k]) fb = fb ^ m_lfsr[taps[k] - 1];
        m_lfsr = {m_lfsr[14:0], fb};
    endtask

    task automatic push_batches(input int n);
        logic [17:0] bt;
        for (int b = 0; b < n; b++) begin
            for (int s = 0; s < 6; s++) begin
                model_step();
                bt[17 - 3 * s -: 3] = face_of(m_lfsr);
            end
            exp_q.push_back(bt);
        end
    endtask

    // Monitor: every ready pulse must match the next predicted batch.
    always @(negedge clk) begin
        if (ready) begin
            logic [17:0] got;
            logic [17:0] want;
            logic        in_range;
            got = {o1, o2, o3, o4, o5, o6};
            ready_cyc.push_back(cyc);
            in_range = 1'b1;
            for (int s = 0; s < 6; s++) if (got[17 - 3 * s -: 3] > 3'd5) in_range = 1'b0;
            check("code_range", in_range, 1);
            check("batch_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                check("batch_codes", got, want);
            end
        end
    end

    // Checker model: echoes the batch after chk_lat cycles (0 = random 1..TIMEOUT).
    bit chk_en     = 1'b1;
    int chk_lat    = 3;
    int corrupt_at = -1;
    int chk_seen   = 0;

    initial begin : checker_model
        logic [17:0] echo;
        int lat;
        {i1, i2, i3, i4, i5, i6} = '0;
        forever begin
            @(negedge clk);
            if (ready) begin
                chk_seen++;
                if (chk_en) begin
                    lat  = (chk_lat == 0) ? int'($urandom_range(TIMEOUT, 1)) : chk_lat;
                    echo = {o1, o2, o3, o4, o5, o6};
                    if (chk_seen == corrupt_at) echo[9] = ~echo[9];
                    repeat (lat) @(negedge clk);
                    {i1, i2, i3, i4, i5, i6} = echo;
                    done = 1'b1;
                    @(negedge clk);
                    done = 1'b0;
                end
            end
        end
    end

    task automatic run(input int n_batches, output int start_cyc);
        push_batches(n_batches);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, output int idle_cyc);
        int k;
        k = 0;
        while (busy && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check({name, "_idle_in_time"}, busy, 0);
        idle_cyc = cyc;
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int s, t, n0, k;
        m_lfsr = SEED;

        repeat (3) @(negedge clk);
        check("reset_outputs",
              {ready, busy, timeout_err, round_cnt, mismatch_cnt, o1, o2, o3, o4, o5, o6}, '0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal run, fixed 3-cycle checker latency
        chk_lat = 3;
        ready_cyc.delete();
        run(ROUNDS, s);
        wait_idle("nominal", t);
        check("nominal_ready_count", ready_cyc.size(), ROUNDS);
        if (ready_cyc.size() == ROUNDS) begin
            check("nominal_first_ready", ready_cyc[0] - s, 7);
            for (int r = 1; r < ROUNDS; r++)
                check("nominal_ready_spacing", ready_cyc[r] - ready_cyc[r - 1], 10);
            check("nominal_busy_fall", t - ready_cyc[ROUNDS - 1], 4);
        end
        check("nominal_round_cnt", round_cnt, ROUNDS);
        check("nominal_timeout_err", timeout_err, 0);

        // Timeout: checker silent
        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        ready_cyc.delete();
        run(1, s);
        wait_idle("timeout", t);
        check("timeout_ready_count", ready_cyc.size(), 1);
        if (ready_cyc.size() == 1) check("timeout_latency", t - ready_cyc[0], 16);
        check("timeout_err_set", timeout_err, 1);
        check("timeout_round_cnt", round_cnt, 0);
        chk_en = 1'b1;

        // done on the final counter cycle still counts; start clears the sticky error
        repeat (2) @(negedge clk);
        chk_lat = TIMEOUT;
        run(ROUNDS, s);
        wait_idle("coincident", t);
        check("coincident_round_cnt", round_cnt, ROUNDS);
        check("coincident_timeout_err", timeout_err, 0);

        // Echo corrupted in round 2
        repeat (2) @(negedge clk);
        chk_lat = 3;
        corrupt_at = chk_seen + 2;
        run(ROUNDS, s);
        wait_idle("mismatch", t);
        check("mismatch_cnt", mismatch_cnt, EXP_MIS);
        check("mismatch_round_cnt", round_cnt, ROUNDS);
        corrupt_at = -1;

        // Stray start and done while generating
        repeat (2) @(negedge clk);
        ready_cyc.delete();
        run(ROUNDS, s);
        start = 1'b1;
        done  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done  = 1'b0;
        wait_idle("ignored", t);
        check("ignored_ready_count", ready_cyc.size(), ROUNDS);
        check("ignored_round_cnt", round_cnt, ROUNDS);
        repeat (10) @(negedge clk);
        check("ignored_no_relaunch", busy, 0);

        // Reset during the third WAIT; the checker's pending done lands afterwards
        n0 = 0;
        k = 0;
        push_batches(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (n0 < 3 && k < 200) begin
            @(negedge clk);
            k++;
            if (ready) n0++;
        end
        check("midrst_third_ready_seen", n0, 3);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_outputs",
              {ready, busy, timeout_err, round_cnt, mismatch_cnt, o1, o2, o3, o4, o5, o6}, '0);
        rst = 1'b1;
        m_lfsr = SEED;
        repeat (20) @(negedge clk);
        check("midrst_late_done_ignored", {busy, round_cnt}, '0);

        // Reseeded sequence restarts; then randomised runs
        run(ROUNDS, s);
        wait_idle("reseed", t);
        check("reseed_round_cnt", round_cnt, ROUNDS);

        chk_lat = 0;
        for (int r = 0; r < 250; r++) begin
            repeat ($urandom_range(3, 0)) @(negedge clk);
            run(ROUNDS, s);
            wait_idle("random", t);
            check("random_round_cnt", round_cnt, ROUNDS);
            check("random_timeout_err", timeout_err, 0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
